// File: rtl/sync_edge_filter_if.sv
// Bundle of the enable, synchronized inputs and filtered outputs/strobes of sync_edge_filter.
`timescale 1ns/1ps
interface sync_edge_filter_if #(
    parameter int WIDTH = 1
);
    logic             ena;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] glitch;

    modport master (
        output ena,
        output d,
        input  q,
        input  rise,
        input  fall,
        input  glitch
    );

    modport slave (
        input  ena,
        input  d,
        output q,
        output rise,
        output fall,
        output glitch
    );
endinterface

// File: rtl/sync_edge_filter.sv
// Per-bit glitch filter and edge detector: q follows d only after STABLE_CYCLES
// consecutive enabled edges of disagreement; registered rise/fall/glitch strobes.
`timescale 1ns/1ps
module sync_edge_filter #(
    parameter int   WIDTH         = 1,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    sync_edge_filter_if.slave   bus
);
    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           state  [WIDTH];
    logic [CW-1:0]    cnt    [WIDTH];
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] glitch_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r      <= {WIDTH{RESET_LEVEL}};
            rise_r   <= '0;
            fall_r   <= '0;
            glitch_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            // Strobes default low every edge, including disabled ones, so they never stretch.
            rise_r   <= '0;
            fall_r   <= '0;
            glitch_r <= '0;
            if (bus.ena) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (bus.d[i] != q_r[i]) begin
                        if (cnt[i] == LAST) begin
                            q_r[i]    <= bus.d[i];
                            rise_r[i] <= bus.d[i];
                            fall_r[i] <= ~bus.d[i];
                            cnt[i]    <= '0;
                            state[i]  <= ST_STABLE;
                        end else begin
                            cnt[i]    <= cnt[i] + CW'(1);
                            state[i]  <= ST_PENDING;
                        end
                    end else if (state[i] == ST_PENDING) begin
                        glitch_r[i] <= 1'b1;
                        cnt[i]      <= '0;
                        state[i]    <= ST_STABLE;
                    end
                end
            end
        end
    end

    assign bus.q      = q_r;
    assign bus.rise   = rise_r;
    assign bus.fall   = fall_r;
    assign bus.glitch = glitch_r;
endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter: vector table, hand-written corner sequences, random run vs. model.
`timescale 1ns/1ps
module tb_sync_edge_filter;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    initial forever #5 clk = ~clk;

    sync_edge_filter_if #(.WIDTH(1)) ifa ();
    sync_edge_filter_if #(.WIDTH(1)) ifb ();
    sync_edge_filter_if #(.WIDTH(4)) ifc ();

    sync_edge_filter #(.WIDTH(1), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    sync_edge_filter #(.WIDTH(1), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));
    sync_edge_filter #(.WIDTH(4), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0))
        dut_c (.clk(clk), .rst(rst_c), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic ena;
        logic d;
        logic q;
        logic r;
        logic f;
        logic g;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic ena, input logic d,
                       input logic q, input logic r, input logic f, input logic g,
                       input int n);
        vec_t v;
        v.rst = rst; v.ena = ena; v.d = d; v.q = q; v.r = r; v.f = f; v.g = g;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the 4-channel instance: each channel remembers the
    // run of enabled samples disagreeing with its accepted level.
    logic [3:0] mq;
    logic [3:0] mr, mf, mg;
    bit         run [4][$];

    task automatic model_edge(input logic rst, input logic ena, input logic [3:0] d);
        mr = '0; mf = '0; mg = '0;
        if (rst) begin
            mq = '0;
            for (int i = 0; i < 4; i++) run[i].delete();
        end else if (ena) begin
            for (int i = 0; i < 4; i++) begin
                if (d[i] != mq[i]) begin
                    run[i].push_back(1'b1);
                    if (run[i].size() == 4) begin
                        mq[i] = d[i];
                        if (d[i]) mr[i] = 1'b1; else mf[i] = 1'b1;
                        run[i].delete();
                    end
                end else if (run[i].size() > 0) begin
                    mg[i] = 1'b1;
                    run[i].delete();
                end
            end
        end
    endtask

    initial begin
        logic       prev;
        logic [3:0] dv;
        logic       rr, ee;

        ifa.ena = 1'b1; ifa.d = 1'b1;
        ifb.ena = 1'b1; ifb.d = 1'b0;
        ifc.ena = 1'b1; ifc.d = 4'b0000;

        // Single-channel, STABLE_CYCLES=4 vectors
        add(1, 1, 1, 0, 0, 0, 0, 1);   // reset with d=1
        add(0, 1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 1, 1, 1, 0, 0, 1);   // rise on 4th edge
        add(0, 1, 1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0, 1, 0, 1);   // fall
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0, 0, 1, 1);   // abandoned run
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 3);   // fresh run needs 4 edges again
        add(0, 1, 1, 1, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 2);   // enable pause mid-run
        add(0, 0, 1, 0, 0, 0, 0, 5);
        add(0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1);   // reset from q=1 gives no fall
        add(0, 1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 0, 1);   // pending count discarded
        add(0, 1, 1, 0, 0, 0, 0, 3);
        add(0, 1, 1, 1, 1, 0, 0, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            rst_a   = tbl[k].rst;
            ifa.ena = tbl[k].ena;
            ifa.d   = tbl[k].d;
            step();
            check($sformatf("tbl[%0d]", k),
                  {12'h0, ifa.q, ifa.rise, ifa.fall, ifa.glitch},
                  {12'h0, tbl[k].q, tbl[k].r, tbl[k].f, tbl[k].g});
        end
        rst_a = 1'b0;

        // STABLE_CYCLES=1 acts as a plain register with alternating strobes
        rst_b = 1'b1;
        step();
        check("b_reset", {12'h0, ifb.q, ifb.rise, ifb.fall, ifb.glitch}, 16'h0);
        rst_b = 1'b0;
        prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ifb.d = ~k[0];
            step();
            check($sformatf("sc1[%0d]", k),
                  {12'h0, ifb.q, ifb.rise, ifb.fall, ifb.glitch},
                  {12'h0, ~k[0], ~k[0] & ~prev, k[0] & prev, 1'b0});
            prev = ~k[0];
        end

        // Four channels: channel independence and mid-run reset
        rst_c = 1'b1;
        step();
        check("c_reset", {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, 16'h0);
        rst_c = 1'b0;
        ifc.d = 4'b0001; step();
        check("c_run1", {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, 16'h0);
        ifc.d = 4'b0101; step();
        step();
        check("c_run3", {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, 16'h0);
        step();
        check("c_ch0_rise", {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, {4'b0001, 4'b0001, 4'b0, 4'b0});
        rst_c = 1'b1; step();
        check("c_midreset", {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, 16'h0);
        rst_c = 1'b0;
        ifc.d = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("c_ch2_wait%0d", k), {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, 16'h0);
        end
        step();
        check("c_ch2_rise", {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, {4'b0100, 4'b0100, 4'b0, 4'b0});

        // Random run against the model; first cycle resets to align states
        dv = 4'b0000;
        for (int k = 0; k < 600; k++) begin
            rr = (k == 0) || ($urandom_range(0, 149) == 0);
            ee = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 4) == 0) dv[i] = ~dv[i];
            rst_c   = rr;
            ifc.ena = ee;
            ifc.d   = dv;
            step();
            model_edge(rr, ee, dv);
            check($sformatf("rand[%0d]", k),
                  {ifc.q, ifc.rise, ifc.fall, ifc.glitch}, {mq, mr, mf, mg});
        end
        rst_c = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
